mul_sequencer: RTL and testbench

Iterative multiply controller for the multicycle ARM core. It executes MUL, UMULL and SMULL using a radix-2 shift-add engine over WIDTH cycles, then sequences one or two register-file write-backs (RdLo, then RdHi). The main control FSM hands off on start, stalls while busy, and resumes on done. The block also produces N/Z flags for the S-suffixed forms.

---
 rtl/mul_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_mul_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_sequencer.sv
// mul_sequencer: iterative multiply controller for the multicycle ARM core.
// Executes MUL / UMULL / SMULL with a radix-2 shift-add engine (WIDTH CALC
// cycles), then sequences one or two register-file write-backs (RdLo, RdHi)
// and a one-cycle done pulse carrying N/Z flags.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   start             request a new multiply (sampled only in IDLE)
//   op                00=MUL, 01=UMULL, 10=SMULL, 11=MUL
//   a, b              multiplicand (Rm) / multiplier (Rs), captured at start
//   rd_lo, rd_hi      write-back destinations, captured at start
//   flush             synchronous abort, no further write-back
//   busy              high whenever the sequencer is not idle
//   reg_we/waddr/wdata  register-file write port (addr/data zero when idle)
//   done              one-cycle completion pulse
//   flag_n, flag_z    result sign / zero, valid while done=1
module mul_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       rd_lo,
  input  logic [3:0]       rd_hi,
  input  logic             flush,
  output logic             busy,
  output logic             reg_we,
  output logic [3:0]       reg_waddr,
  output logic [WIDTH-1:0] reg_wdata,
  output logic             done,
  output logic             flag_n,
  output logic             flag_z
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_WB_LO,
    S_WB_HI,
    S_DONE
  } state_t;

  state_t               r_state;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [CW-1:0]        r_cnt;
  logic                 r_long;
  logic                 r_neg;
  logic [3:0]           r_rd_lo;
  logic [3:0]           r_rd_hi;

  logic [WIDTH-1:0]     w_addend;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_acc_shift;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_abs_a;
  logic [WIDTH-1:0]     w_abs_b;
  logic                 w_is_smull;
  logic                 w_last;

  always_comb begin
    w_is_smull  = (op == 2'b10);
    // Magnitudes for SMULL; the most negative value maps onto itself,
    // which read unsigned is the correct magnitude.
    w_abs_a     = (w_is_smull && a[WIDTH-1]) ? -a : a;
    w_abs_b     = (w_is_smull && b[WIDTH-1]) ? -b : b;
    w_addend    = r_mplier[0] ? r_mcand : '0;
    // Adder carry-out becomes the bit shifted into the accumulator MSB.
    w_sum       = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
    w_acc_shift = {w_sum, r_acc[WIDTH-1:1]};
    w_prod      = r_neg ? -w_acc_shift : w_acc_shift;
    w_last      = (r_cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_cnt     <= '0;
      r_long    <= 1'b0;
      r_neg     <= 1'b0;
      r_rd_lo   <= '0;
      r_rd_hi   <= '0;
      busy      <= 1'b0;
      reg_we    <= 1'b0;
      reg_waddr <= '0;
      reg_wdata <= '0;
      done      <= 1'b0;
      flag_n    <= 1'b0;
      flag_z    <= 1'b0;
    end else begin
      // Outputs describe the state being entered; default to idle values.
      reg_we    <= 1'b0;
      reg_waddr <= '0;
      reg_wdata <= '0;
      done      <= 1'b0;
      flag_n    <= 1'b0;
      flag_z    <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start && !flush) begin
            r_mcand  <= w_abs_a;
            r_mplier <= w_abs_b;
            r_long   <= (op == 2'b01) || (op == 2'b10);
            r_neg    <= w_is_smull && (a[WIDTH-1] ^ b[WIDTH-1]);
            r_rd_lo  <= rd_lo;
            r_rd_hi  <= rd_hi;
            r_acc    <= '0;
            r_cnt    <= '0;
            busy     <= 1'b1;
            r_state  <= S_CALC;
          end
        end

        S_CALC: begin
          if (flush) begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
            if (w_last) begin
              r_acc     <= w_prod;
              reg_we    <= 1'b1;
              reg_waddr <= r_rd_lo;
              reg_wdata <= w_prod[WIDTH-1:0];
              r_state   <= S_WB_LO;
            end else begin
              r_acc <= w_acc_shift;
            end
          end
        end

        S_WB_LO: begin
          if (flush) begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_long) begin
            reg_we    <= 1'b1;
            reg_waddr <= r_rd_hi;
            reg_wdata <= r_acc[2*WIDTH-1:WIDTH];
            r_state   <= S_WB_HI;
          end else begin
            done    <= 1'b1;
            flag_n  <= r_acc[WIDTH-1];
            flag_z  <= (r_acc[WIDTH-1:0] == '0);
            r_state <= S_DONE;
          end
        end

        S_WB_HI: begin
          if (flush) begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            done    <= 1'b1;
            flag_n  <= r_acc[2*WIDTH-1];
            flag_z  <= (r_acc == '0);
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
module tb_mul_sequencer;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    op = '0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [3:0]    rd_lo = '0;
  logic [3:0]    rd_hi = '0;
  logic          flush = 1'b0;
  logic          busy;
  logic          reg_we;
  logic [3:0]    reg_waddr;
  logic [W-1:0]  reg_wdata;
  logic          done;
  logic          flag_n;
  logic          flag_z;

  mul_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .rd_lo(rd_lo), .rd_hi(rd_hi), .flush(flush), .busy(busy),
    .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .done(done), .flag_n(flag_n), .flag_z(flag_z)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference product from plain arithmetic.
  function automatic logic [2*W-1:0] prod_of(input logic [1:0] o, input logic [W-1:0] x,
                                             input logic [W-1:0] y);
    logic signed [2*W-1:0] sx, sy;
    logic [2*W-1:0] p;
    if (o == 2'b10) begin
      sx = {{W{x[W-1]}}, x};
      sy = {{W{y[W-1]}}, y};
      p  = sx * sy;
    end else begin
      p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    end
    return p;
  endfunction

  // Model: an accepted job occupies cycles 1..len after acceptance; writes
  // land in cycles W+1 (low) and W+2 (high, long forms), done in cycle len.
  logic          m_act = 1'b0;
  int            m_k = 0;
  logic          m_long = 1'b0;
  logic [3:0]    m_lo = '0, m_hi = '0;
  logic [2*W-1:0] m_prod = '0;
  int            m_len;
  assign m_len = m_long ? W + 3 : W + 2;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_act <= 1'b0;
      m_k   <= 0;
    end else if (m_act) begin
      if (flush || m_k == m_len) m_act <= 1'b0;
      else m_k <= m_k + 1;
    end else if (start && !flush) begin
      m_act  <= 1'b1;
      m_k    <= 1;
      m_long <= (op == 2'b01) || (op == 2'b10);
      m_lo   <= rd_lo;
      m_hi   <= rd_hi;
      m_prod <= prod_of(op, a, b);
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    logic e_we, e_done, e_n, e_z;
    logic [3:0] e_addr;
    logic [W-1:0] e_data;
    e_we = m_act && (m_k == W + 1 || (m_long && m_k == W + 2));
    e_addr = '0;
    e_data = '0;
    if (e_we && m_k == W + 1) begin e_addr = m_lo; e_data = m_prod[W-1:0]; end
    if (e_we && m_k == W + 2) begin e_addr = m_hi; e_data = m_prod[2*W-1:W]; end
    e_done = m_act && m_k == m_len;
    e_n = e_done && (m_long ? m_prod[2*W-1] : m_prod[W-1]);
    e_z = e_done && (m_long ? (m_prod == '0) : (m_prod[W-1:0] == '0));
    chk("busy", 64'(busy), 64'(m_act));
    chk("reg_we", 64'(reg_we), 64'(e_we));
    chk("reg_waddr", 64'(reg_waddr), 64'(e_addr));
    chk("reg_wdata", 64'(reg_wdata), 64'(e_data));
    chk("done", 64'(done), 64'(e_done));
    chk("flag_n", 64'(flag_n), 64'(e_n));
    chk("flag_z", 64'(flag_z), 64'(e_z));
  end

  // Directed-run records (cycle 1 = first cycle after the accepting edge).
  int         wr_n;
  int         wr_cyc [4];
  logic [3:0] wr_addr [4];
  logic [W-1:0] wr_data [4];
  int         done_c;
  logic       d_n, d_z;
  logic       busy_at [80];

  task automatic run(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic [3:0] lo, input logic [3:0] hi,
                     input int ign_at, input int flush_at, input int restart_at, input int ncyc);
    wr_n = 0; done_c = -1; d_n = 1'b0; d_z = 1'b0;
    for (int i = 0; i < 80; i++) busy_at[i] = 1'b0;
    @(negedge clk);
    op = o; a = x; b = y; rd_lo = lo; rd_hi = hi; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      busy_at[c] = busy;
      if (reg_we) begin
        if (wr_n < 4) begin
          wr_cyc[wr_n] = c; wr_addr[wr_n] = reg_waddr; wr_data[wr_n] = reg_wdata;
        end
        wr_n++;
      end
      if (done && done_c < 0) begin done_c = c; d_n = flag_n; d_z = flag_z; end
      start = 1'b0;
      flush = 1'b0;
      if (c == ign_at) begin
        start = 1'b1; op = 2'b01; a = 32'hDEADBEEF; b = 32'h0BADF00D; rd_lo = 4'hE; rd_hi = 4'hF;
      end
      if (c == restart_at) begin
        start = 1'b1; op = o; a = x; b = y; rd_lo = lo; rd_hi = hi;
      end
      if (c == flush_at) flush = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_we", 64'(reg_we), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_wdata", 64'(reg_wdata), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // MUL 7*6 -> r3
    run(2'b00, 32'd7, 32'd6, 4'd3, 4'd9, -1, -1, -1, 40);
    chk("mul_nwr", 64'(wr_n), 64'd1);
    chk("mul_wcyc", 64'(wr_cyc[0]), 64'd33);
    chk("mul_waddr", 64'(wr_addr[0]), 64'd3);
    chk("mul_wdata", 64'(wr_data[0]), 64'h2A);
    chk("mul_done", 64'(done_c), 64'd34);
    chk("mul_nz", 64'({d_n, d_z}), 64'd0);
    chk("mul_busy1", 64'(busy_at[1]), 64'd1);
    chk("mul_busy34", 64'(busy_at[34]), 64'd1);
    chk("mul_busy35", 64'(busy_at[35]), 64'd0);

    // UMULL FFFFFFFF^2
    run(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd1, 4'd2, -1, -1, -1, 40);
    chk("umull_nwr", 64'(wr_n), 64'd2);
    chk("umull_lo", 64'({wr_cyc[0][7:0], wr_addr[0], wr_data[0]}), {24'd0, 8'd33, 4'd1, 32'h1});
    chk("umull_hi", 64'({wr_cyc[1][7:0], wr_addr[1], wr_data[1]}), {24'd0, 8'd34, 4'd2, 32'hFFFFFFFE});
    chk("umull_done", 64'(done_c), 64'd35);
    chk("umull_n", 64'(d_n), 64'd1);

    // SMULL -3*5
    run(2'b10, 32'hFFFFFFFD, 32'd5, 4'd4, 4'd5, -1, -1, -1, 40);
    chk("smull_lo", 64'(wr_data[0]), 64'hFFFFFFF1);
    chk("smull_hi", 64'(wr_data[1]), 64'hFFFFFFFF);
    chk("smull_nz", 64'({d_n, d_z}), 64'b10);

    // SMULL 0x80000000^2
    run(2'b10, 32'h80000000, 32'h80000000, 4'd6, 4'd7, -1, -1, -1, 40);
    chk("smin_lo", 64'(wr_data[0]), 64'h0);
    chk("smin_hi", 64'(wr_data[1]), 64'h40000000);
    chk("smin_n", 64'(d_n), 64'd0);

    // MUL 0*x with an ignored start in cycle 10
    run(2'b00, 32'd0, 32'h12345678, 4'd7, 4'd8, 10, -1, -1, 40);
    chk("zero_nwr", 64'(wr_n), 64'd1);
    chk("zero_w", 64'({wr_cyc[0][7:0], wr_addr[0], wr_data[0]}), {24'd0, 8'd33, 4'd7, 32'h0});
    chk("zero_done", 64'(done_c), 64'd34);
    chk("zero_z", 64'(d_z), 64'd1);

    // UMULL flushed in cycle 20, restart in cycle 22
    run(2'b01, 32'h1234, 32'h5678, 4'd1, 4'd2, -1, 20, 22, 22);
    chk("flush_nwr", 64'(wr_n), 64'd0);
    chk("flush_done", 64'(done_c), -64'sd1);
    chk("flush_busy20", 64'(busy_at[20]), 64'd1);
    chk("flush_busy21", 64'(busy_at[21]), 64'd0);
    chk("flush_busy22", 64'(busy_at[22]), 64'd0);
    chk("restart_busy", 64'(busy), 64'd1);
    repeat (40) @(negedge clk);
    chk("restart_idle", 64'(busy), 64'd0);

    // Async reset during WB_LO of UMULL
    run(2'b01, 32'h3, 32'h5, 4'd1, 4'd2, -1, -1, -1, 32);
    chk("pre_rst_we", 64'(reg_we), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_outs", 64'({busy, reg_we, reg_waddr, reg_wdata, done, flag_n, flag_z}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_we", 64'(reg_we), 64'd0);
    end

    // Randomized traffic checked by the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 7) == 0);
      op    = 2'($urandom);
      a     = rnd_opnd();
      b     = rnd_opnd();
      rd_lo = 4'($urandom);
      rd_hi = ($urandom_range(0, 7) == 0) ? rd_lo : 4'($urandom);
      flush = ($urandom_range(0, 127) == 0);
    end
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    repeat (40) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
